// File: rtl/dsp_cmd_pkg.sv
// Opcodes, field widths and frame-length rules shared by the command encoder and the engine-side decoder.
// No logic; both ends derive frame sizes from the same function so they cannot disagree.
package dsp_cmd_pkg;

    localparam logic [7:0] CMD_WRITE_INSTR  = 8'h01;
    localparam logic [7:0] CMD_WRITE_REG    = 8'h02;
    localparam logic [7:0] CMD_UPDATE_REG   = 8'h03;
    localparam logic [7:0] CMD_COMMIT       = 8'h04;
    localparam logic [7:0] CMD_ALLOC_DELAY  = 8'h05;
    localparam logic [7:0] CMD_SWAP         = 8'h06;
    localparam logic [7:0] CMD_RESET_PIPE   = 8'h07;
    localparam logic [7:0] CMD_SET_IN_GAIN  = 8'h08;
    localparam logic [7:0] CMD_SET_OUT_GAIN = 8'h09;

    localparam int OPCODE_W = 8;
    localparam int BLOCK_W  = 8;
    localparam int REG_W    = 4;
    localparam int DELAY_W  = 32;

    // Total bytes on the wire including the opcode; 0 marks an unknown opcode.
    function automatic int frame_len(input logic [7:0] opcode, input int data_bytes,
                                     input int instr_bytes);
        case (opcode)
            CMD_WRITE_INSTR:                   frame_len = 2 + instr_bytes;
            CMD_WRITE_REG, CMD_UPDATE_REG:     frame_len = 3 + data_bytes;
            CMD_COMMIT, CMD_SWAP,
            CMD_RESET_PIPE:                    frame_len = 1;
            CMD_ALLOC_DELAY:                   frame_len = 2 + DELAY_W / 8;
            CMD_SET_IN_GAIN, CMD_SET_OUT_GAIN: frame_len = 1 + data_bytes;
            default:                           frame_len = 0;
        endcase
    endfunction

    function automatic int max_frame_len(input int data_bytes, input int instr_bytes);
        int m;
        m = 2 + instr_bytes;
        if (3 + data_bytes > m)  m = 3 + data_bytes;
        if (2 + DELAY_W / 8 > m) m = 2 + DELAY_W / 8;
        return m;
    endfunction

endpackage

// File: rtl/cmd_shift_tx.sv
// Parallel-load frame register that presents its top byte and shifts left one byte per emit.
// Latency: top_byte valid the cycle after load; backpressure is the caller withholding shift.
// Counter is armed separately so the length can be latched with the frame and started one cycle later.
module cmd_shift_tx #(
    parameter int FRAME_BYTES = 6,
    parameter int CNT_W       = 3
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     load,
    input  logic [FRAME_BYTES*8-1:0] load_frame,
    input  logic [CNT_W-1:0]         load_len,
    input  logic                     arm,
    input  logic                     shift,
    output logic [7:0]               top_byte,
    output logic                     last
);

    localparam int FRAME_W = FRAME_BYTES * 8;

    logic [FRAME_W-1:0] shreg;
    logic [CNT_W-1:0]   len_q;
    logic [CNT_W-1:0]   cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            shreg <= '0;
            len_q <= '0;
            cnt   <= '0;
        end else begin
            if (load) begin
                shreg <= load_frame;
                len_q <= load_len;
            end else if (shift) begin
                shreg <= {shreg[FRAME_W-9:0], 8'h00};
            end

            if (arm) begin
                cnt <= len_q;
            end else if (shift) begin
                cnt <= cnt - CNT_W'(1);
            end
        end
    end

    assign top_byte = shreg[FRAME_W-1 -: 8];
    assign last     = (cnt == CNT_W'(1));

endmodule

// File: rtl/dsp_command_encoder.sv
// Serialises one structured engine command per handshake into MSB-first framed bytes.
// Latency: first byte strobe 2 cycles after the accepting edge, then at most one byte every 2 cycles.
// Backpressure: req_ready low for the whole frame; emission stalls while the engine FIFO lacks headroom.
module dsp_command_encoder
    import dsp_cmd_pkg::*;
#(
    parameter int n_blocks        = 255,
    parameter int data_width      = 16,
    parameter int instr_width     = 32,
    parameter int spi_fifo_length = 32,
    parameter int fifo_margin     = 2
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               req_valid,
    output logic                               req_ready,
    input  logic [OPCODE_W-1:0]                req_opcode,
    input  logic [BLOCK_W-1:0]                 req_block,
    input  logic [REG_W-1:0]                   req_reg,
    input  logic [data_width-1:0]              req_data,
    input  logic [DELAY_W-1:0]                 req_delay,
    input  logic [instr_width-1:0]             req_instr,
    input  logic [$clog2(spi_fifo_length):0]   fifo_count,
    output logic [7:0]                         cmd_byte,
    output logic                               cmd_byte_valid,
    output logic                               bad_opcode,
    output logic                               busy
);

    localparam int DATA_BYTES  = data_width / 8;
    localparam int INSTR_BYTES = instr_width / 8;
    localparam int FRAME_BYTES = max_frame_len(DATA_BYTES, INSTR_BYTES);
    localparam int FRAME_W     = FRAME_BYTES * 8;
    localparam int CNT_W       = $clog2(FRAME_BYTES + 1);

    generate
        if (n_blocks < 1 || n_blocks > 256 || data_width % 8 != 0 || instr_width % 8 != 0) begin : g_bad_params
            $error("dsp_command_encoder: unsupported parameter combination");
        end
    endgenerate

    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_EMIT} state_t;

    state_t             state, state_next;
    logic [FRAME_W-1:0] frame;
    int                 req_len;
    logic               accept, drop, arm, emit, room, last;
    logic [7:0]         top_byte;

    // Frames are left-aligned so the opcode is always the first byte shifted out.
    always_comb begin
        frame = '0;
        case (req_opcode)
            CMD_WRITE_INSTR:
                frame[FRAME_W-1 -: 16+instr_width] = {req_opcode, req_block, req_instr};
            CMD_WRITE_REG, CMD_UPDATE_REG:
                frame[FRAME_W-1 -: 24+data_width] = {req_opcode, req_block, 4'h0, req_reg, req_data};
            CMD_ALLOC_DELAY:
                frame[FRAME_W-1 -: 16+DELAY_W] = {req_opcode, req_block, req_delay};
            CMD_SET_IN_GAIN, CMD_SET_OUT_GAIN:
                frame[FRAME_W-1 -: 8+data_width] = {req_opcode, req_data};
            default:
                frame[FRAME_W-1 -: 8] = req_opcode;
        endcase
    end

    assign req_len = frame_len(req_opcode, DATA_BYTES, INSTR_BYTES);
    // Counts at or above the depth fail this test too, so an overfull report is simply "no room".
    assign room    = (int'(fifo_count) + fifo_margin) < spi_fifo_length;

    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        drop       = 1'b0;
        arm        = 1'b0;
        emit       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (req_valid) begin
                    if (req_len != 0) begin
                        accept     = 1'b1;
                        state_next = ST_LOAD;
                    end else begin
                        drop = 1'b1;
                    end
                end
            end
            ST_LOAD: begin
                arm        = 1'b1;
                state_next = ST_EMIT;
            end
            ST_EMIT: begin
                // Skipping the cycle after a strobe lets fifo_count reflect that byte first.
                if (room && !cmd_byte_valid) begin
                    emit = 1'b1;
                    if (last) state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign req_ready = (state == ST_IDLE);
    assign busy      = (state != ST_IDLE);

    cmd_shift_tx #(
        .FRAME_BYTES (FRAME_BYTES),
        .CNT_W       (CNT_W)
    ) u_shift_tx (
        .clk        (clk),
        .reset      (reset),
        .load       (accept),
        .load_frame (frame),
        .load_len   (CNT_W'(req_len)),
        .arm        (arm),
        .shift      (emit),
        .top_byte   (top_byte),
        .last       (last)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            cmd_byte       <= '0;
            cmd_byte_valid <= 1'b0;
            bad_opcode     <= 1'b0;
        end else begin
            cmd_byte_valid <= emit;
            bad_opcode     <= drop;
            if (emit) cmd_byte <= top_byte;
        end
    end

endmodule

// File: tb/tb_dsp_command_encoder.sv
// Bench for dsp_command_encoder: directed scenarios plus randomized commands under random FIFO fill,
// checked against a byte-list model built from the frame layouts.
module tb_dsp_command_encoder;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [7:0]  req_opcode;
    logic [7:0]  req_block;
    logic [3:0]  req_reg;
    logic [15:0] req_data;
    logic [31:0] req_delay;
    logic [31:0] req_instr;
    logic [5:0]  fifo_count;
    logic [7:0]  cmd_byte;
    logic        cmd_byte_valid;
    logic        bad_opcode;
    logic        busy;

    int checks = 0;
    int errors = 0;

    dsp_command_encoder dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_opcode(req_opcode), .req_block(req_block), .req_reg(req_reg),
        .req_data(req_data), .req_delay(req_delay), .req_instr(req_instr),
        .fifo_count(fifo_count), .cmd_byte(cmd_byte), .cmd_byte_valid(cmd_byte_valid),
        .bad_opcode(bad_opcode), .busy(busy)
    );

    always #5 clk = ~clk;

    // Observers: each variable below has exactly one writer.
    int         cyc = 0;
    int         hs_cnt = 0;
    int         hs_cyc = 0;
    logic [5:0] last_fc = '0;
    logic [7:0] rx_q[$];
    int         rx_t[$];
    int         busy_cnt = 0;
    int         bad_cnt = 0;
    int         consec = 0;
    int         fc_viol = 0;
    bit         prev_v = 1'b0;

    always @(posedge clk) begin
        cyc     <= cyc + 1;
        last_fc <= fifo_count;
        if (!reset && req_valid && req_ready) begin
            hs_cnt <= hs_cnt + 1;
            hs_cyc <= cyc + 1;
        end
    end

    always @(negedge clk) begin
        if (cmd_byte_valid) begin
            rx_q.push_back(cmd_byte);
            rx_t.push_back(cyc);
            if (prev_v) consec = consec + 1;
            if (int'(last_fc) + 2 >= 32) fc_viol = fc_viol + 1;
        end
        prev_v = cmd_byte_valid;
        if (busy) busy_cnt = busy_cnt + 1;
        if (bad_opcode) bad_cnt = bad_cnt + 1;
    end

    logic [7:0] exp_q[$];

    // Expected wire bytes straight from the frame layouts.
    task automatic build_exp(input logic [7:0] op, input logic [7:0] blk, input logic [3:0] rg,
                             input logic [15:0] dat, input logic [31:0] dly, input logic [31:0] ins);
        exp_q.delete();
        exp_q.push_back(op);
        case (op)
            8'h01: begin
                exp_q.push_back(blk);
                for (int k = 3; k >= 0; k--) exp_q.push_back(8'(ins >> (8 * k)));
            end
            8'h02, 8'h03: begin
                exp_q.push_back(blk);
                exp_q.push_back({4'h0, rg});
                for (int k = 1; k >= 0; k--) exp_q.push_back(8'(dat >> (8 * k)));
            end
            8'h05: begin
                exp_q.push_back(blk);
                for (int k = 3; k >= 0; k--) exp_q.push_back(8'(dly >> (8 * k)));
            end
            8'h08, 8'h09: begin
                for (int k = 1; k >= 0; k--) exp_q.push_back(8'(dat >> (8 * k)));
            end
            default: ;
        endcase
    endtask

    task automatic send_req(input logic [7:0] op, input logic [7:0] blk, input logic [3:0] rg,
                            input logic [15:0] dat, input logic [31:0] dly, input logic [31:0] ins);
        int n = 0;
        while (!req_ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            checks++;
            errors++;
            $display("FAIL send_req_timeout: req_ready=%b required 1", req_ready);
        end
        req_opcode = op; req_block = blk; req_reg = rg;
        req_data = dat; req_delay = dly; req_instr = ins;
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic wait_idle(input bit rnd_fc, input int budget);
        int n = 0;
        while ((busy || !req_ready) && n < budget) begin
            if (rnd_fc) fifo_count = 6'($urandom_range(24, 33));
            @(negedge clk);
            n++;
        end
        checks++;
        if (busy) begin
            errors++;
            $display("FAIL wait_idle_timeout: busy=%b required 0", busy);
        end
        fifo_count = '0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset;
        reset = 1'b1; req_valid = 1'b0; req_opcode = '0; req_block = '0; req_reg = '0;
        req_data = '0; req_delay = '0; req_instr = '0; fifo_count = '0;
        repeat (3) @(negedge clk);
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready: got %b want 1", req_ready); end
        checks++; if (cmd_byte !== 8'h00) begin errors++; $display("FAIL reset_cmd_byte: got %h want 00", cmd_byte); end
        checks++; if (cmd_byte_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", cmd_byte_valid); end
        checks++; if (bad_opcode !== 1'b0) begin errors++; $display("FAIL reset_bad_opcode: got %b want 0", bad_opcode); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_swap;
        int rb = rx_q.size();
        int bb = busy_cnt;
        send_req(8'h06, 8'h00, 4'h0, 16'h0, 32'h0, 32'h0);
        wait_idle(1'b0, 50);
        checks++; if (rx_q.size() - rb != 1) begin errors++; $display("FAIL swap_count: got %0d want 1", rx_q.size() - rb); end
        if (rx_q.size() > rb) begin
            checks++; if (rx_q[rb] !== 8'h06) begin errors++; $display("FAIL swap_byte: got %h want 06", rx_q[rb]); end
            checks++; if (rx_t[rb] != hs_cyc + 2) begin errors++; $display("FAIL swap_latency: got %0d want %0d", rx_t[rb] - hs_cyc, 2); end
        end
        checks++; if (busy_cnt - bb != 2) begin errors++; $display("FAIL swap_busy_cycles: got %0d want 2", busy_cnt - bb); end
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL swap_req_ready: got %b want 1", req_ready); end
    endtask

    task automatic test_write_reg;
        int rb = rx_q.size();
        logic [7:0] got;
        build_exp(8'h02, 8'h12, 4'h3, 16'hBEEF, 32'h0, 32'h0);
        send_req(8'h02, 8'h12, 4'h3, 16'hBEEF, 32'h0, 32'h0);
        wait_idle(1'b0, 100);
        checks++; if (rx_q.size() - rb != exp_q.size()) begin errors++; $display("FAIL wreg_count: got %0d want %0d", rx_q.size() - rb, exp_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            got = (rb + i < rx_q.size()) ? rx_q[rb + i] : 8'hxx;
            checks++; if (got !== exp_q[i]) begin errors++; $display("FAIL wreg_byte%0d: got %h want %h", i, got, exp_q[i]); end
            if (i > 0 && rb + i < rx_q.size()) begin
                checks++; if (rx_t[rb + i] - rx_t[rb + i - 1] < 2) begin errors++; $display("FAIL wreg_gap%0d: got %0d want >=2", i, rx_t[rb + i] - rx_t[rb + i - 1]); end
            end
        end
    endtask

    task automatic test_throttle;
        int rb = rx_q.size();
        logic [31:0] ins = $urandom;
        logic [7:0] got;
        fifo_count = 6'd30;
        build_exp(8'h01, 8'h5A, 4'h0, 16'h0, 32'h0, ins);
        send_req(8'h01, 8'h5A, 4'h0, 16'h0, 32'h0, ins);
        repeat (20) @(negedge clk);
        checks++; if (rx_q.size() != rb) begin errors++; $display("FAIL throttle_stall: got %0d strobes want 0", rx_q.size() - rb); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL throttle_busy: got %b want 1", busy); end
        fifo_count = 6'd29;
        wait_idle(1'b0, 100);
        checks++; if (rx_q.size() - rb != exp_q.size()) begin errors++; $display("FAIL throttle_count: got %0d want %0d", rx_q.size() - rb, exp_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            got = (rb + i < rx_q.size()) ? rx_q[rb + i] : 8'hxx;
            checks++; if (got !== exp_q[i]) begin errors++; $display("FAIL throttle_byte%0d: got %h want %h", i, got, exp_q[i]); end
        end
    endtask

    task automatic test_bad_opcode;
        int rb  = rx_q.size();
        int bdb = bad_cnt;
        send_req(8'h7F, 8'h01, 4'h1, 16'h1234, 32'h0, 32'h0);
        repeat (5) @(negedge clk);
        checks++; if (bad_cnt - bdb != 1) begin errors++; $display("FAIL bad_pulse: got %0d cycles want 1", bad_cnt - bdb); end
        checks++; if (rx_q.size() != rb) begin errors++; $display("FAIL bad_strobes: got %0d want 0", rx_q.size() - rb); end
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL bad_req_ready: got %b want 1", req_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bad_busy: got %b want 0", busy); end
    endtask

    task automatic test_reset_mid;
        int rb = rx_q.size();
        int n = 0;
        int held;
        logic [7:0] got;
        build_exp(8'h05, 8'h33, 4'h0, 16'h0, 32'hCAFE_F00D, 32'h0);
        send_req(8'h05, 8'h33, 4'h0, 16'h0, 32'hCAFE_F00D, 32'h0);
        while (rx_q.size() < rb + 2 && n < 100) begin
            @(negedge clk);
            n++;
        end
        held = rx_q.size();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b want 0", busy); end
        reset = 1'b0;
        repeat (20) @(negedge clk);
        checks++; if (held != rb + 2) begin errors++; $display("FAIL rstmid_prefix: got %0d bytes want 2", held - rb); end
        checks++; if (rx_q.size() != held) begin errors++; $display("FAIL rstmid_extra: got %0d extra bytes want 0", rx_q.size() - held); end
        for (int i = 0; i < 2; i++) begin
            got = (rb + i < rx_q.size()) ? rx_q[rb + i] : 8'hxx;
            checks++; if (got !== exp_q[i]) begin errors++; $display("FAIL rstmid_byte%0d: got %h want %h", i, got, exp_q[i]); end
        end
        rb = rx_q.size();
        send_req(8'h06, 8'h00, 4'h0, 16'h0, 32'h0, 32'h0);
        wait_idle(1'b0, 50);
        checks++; if (rx_q.size() - rb != 1) begin errors++; $display("FAIL rstmid_swap_count: got %0d want 1", rx_q.size() - rb); end
        got = (rb < rx_q.size()) ? rx_q[rb] : 8'hxx;
        checks++; if (got !== 8'h06) begin errors++; $display("FAIL rstmid_swap_byte: got %h want 06", got); end
    endtask

    task automatic test_back_to_back;
        int rb = rx_q.size();
        int hb = hs_cnt;
        int n = 0;
        int swap_acc;
        logic [7:0] got;
        req_opcode = 8'h04; req_valid = 1'b1;
        while (hs_cnt < hb + 1 && n < 50) begin @(negedge clk); n++; end
        req_opcode = 8'h06;
        n = 0;
        while (hs_cnt < hb + 2 && n < 50) begin @(negedge clk); n++; end
        req_valid = 1'b0;
        swap_acc = hs_cyc;
        wait_idle(1'b0, 50);
        checks++; if (hs_cnt - hb != 2) begin errors++; $display("FAIL b2b_handshakes: got %0d want 2", hs_cnt - hb); end
        checks++; if (rx_q.size() - rb != 2) begin errors++; $display("FAIL b2b_count: got %0d want 2", rx_q.size() - rb); end
        got = (rb < rx_q.size()) ? rx_q[rb] : 8'hxx;
        checks++; if (got !== 8'h04) begin errors++; $display("FAIL b2b_first: got %h want 04", got); end
        got = (rb + 1 < rx_q.size()) ? rx_q[rb + 1] : 8'hxx;
        checks++; if (got !== 8'h06) begin errors++; $display("FAIL b2b_second: got %h want 06", got); end
        if (rb < rx_q.size()) begin
            checks++; if (swap_acc <= rx_t[rb]) begin errors++; $display("FAIL b2b_order: swap accepted cycle %0d, want after %0d", swap_acc, rx_t[rb]); end
        end
    endtask

    task automatic test_random;
        logic [7:0]  op, blk;
        logic [3:0]  rg;
        logic [15:0] dat;
        logic [31:0] dly, ins;
        logic [7:0]  got;
        int rb;
        for (int t = 0; t < 30; t++) begin
            op  = 8'($urandom_range(1, 9));
            blk = 8'($urandom); rg = 4'($urandom); dat = 16'($urandom);
            dly = $urandom; ins = $urandom;
            rb  = rx_q.size();
            build_exp(op, blk, rg, dat, dly, ins);
            send_req(op, blk, rg, dat, dly, ins);
            wait_idle(1'b1, 2000);
            checks++; if (rx_q.size() - rb != exp_q.size()) begin errors++; $display("FAIL rand%0d_count op=%h: got %0d want %0d", t, op, rx_q.size() - rb, exp_q.size()); end
            for (int i = 0; i < exp_q.size(); i++) begin
                got = (rb + i < rx_q.size()) ? rx_q[rb + i] : 8'hxx;
                checks++; if (got !== exp_q[i]) begin errors++; $display("FAIL rand%0d_byte%0d op=%h: got %h want %h", t, i, op, got, exp_q[i]); end
            end
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        checks++; if (fc_viol != 0) begin errors++; $display("FAIL fifo_headroom: got %0d strobes into a full FIFO want 0", fc_viol); end
        checks++; if (consec != 0) begin errors++; $display("FAIL strobe_spacing: got %0d consecutive strobes want 0", consec); end
    endtask

    initial begin
        @(negedge clk);
        test_reset;
        test_swap;
        test_write_reg;
        test_throttle;
        test_bad_opcode;
        test_reset_mid;
        test_back_to_back;
        test_random;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
